// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode encodings and the
// result codes returned by the comparison operations.
package alu_pkg;

   localparam int unsigned SEL_W = 4;

   localparam logic [SEL_W-1:0] ALU_ADD   = 4'b0000;
   localparam logic [SEL_W-1:0] ALU_SUB   = 4'b0001;
   localparam logic [SEL_W-1:0] ALU_MUL   = 4'b0010;
   localparam logic [SEL_W-1:0] ALU_DIV   = 4'b0011;
   localparam logic [SEL_W-1:0] ALU_AND   = 4'b0100;
   localparam logic [SEL_W-1:0] ALU_OR    = 4'b0101;
   localparam logic [SEL_W-1:0] ALU_NAND  = 4'b0110;
   localparam logic [SEL_W-1:0] ALU_NOR   = 4'b0111;
   localparam logic [SEL_W-1:0] ALU_NOP   = 4'b1000;
   localparam logic [SEL_W-1:0] ALU_EQ    = 4'b1001;
   localparam logic [SEL_W-1:0] ALU_GT    = 4'b1010;
   localparam logic [SEL_W-1:0] ALU_LT    = 4'b1011;
   localparam logic [SEL_W-1:0] ALU_SHR_A = 4'b1100;
   localparam logic [SEL_W-1:0] ALU_SHL_A = 4'b1101;
   localparam logic [SEL_W-1:0] ALU_SHR_B = 4'b1110;
   localparam logic [SEL_W-1:0] ALU_SHL_B = 4'b1111;

   localparam int unsigned CMP_EQ = 1;
   localparam int unsigned CMP_GT = 2;
   localparam int unsigned CMP_LT = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational result mux of the ALU. Operands are widened to the output
// width first so carries, borrows and left-shift overflow land in the upper byte.
module alu_core
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int SELECTION_LINE = 4
) (
   input  logic [DATA_WIDTH-1:0]     i_a,
   input  logic [DATA_WIDTH-1:0]     i_b,
   input  logic [SELECTION_LINE-1:0] i_fun,
   output logic [2*DATA_WIDTH-1:0]   o_result
);

   localparam int OW = 2 * DATA_WIDTH;

   logic [OW-1:0] w_a;
   logic [OW-1:0] w_b;
   logic [OW-1:0] w_zero_hi;

   assign w_a       = {{DATA_WIDTH{1'b0}}, i_a};
   assign w_b       = {{DATA_WIDTH{1'b0}}, i_b};
   assign w_zero_hi = '0;

   always_comb begin
      o_result = '0;
      case (i_fun)
         ALU_ADD:   o_result = w_a + w_b;
         ALU_SUB:   o_result = w_a - w_b;
         ALU_MUL:   o_result = w_a * w_b;
         // Division by zero is defined as 0 rather than left to the tools.
         ALU_DIV:   o_result = (i_b == '0) ? w_zero_hi : (w_a / w_b);
         ALU_AND:   o_result = {{DATA_WIDTH{1'b0}}, i_a & i_b};
         ALU_OR:    o_result = {{DATA_WIDTH{1'b0}}, i_a | i_b};
         ALU_NAND:  o_result = {{DATA_WIDTH{1'b0}}, ~(i_a & i_b)};
         ALU_NOR:   o_result = {{DATA_WIDTH{1'b0}}, ~(i_a | i_b)};
         ALU_NOP:   o_result = '0;
         ALU_EQ:    o_result = (i_a == i_b) ? OW'(CMP_EQ) : w_zero_hi;
         ALU_GT:    o_result = (i_a > i_b)  ? OW'(CMP_GT) : w_zero_hi;
         ALU_LT:    o_result = (i_a < i_b)  ? OW'(CMP_LT) : w_zero_hi;
         ALU_SHR_A: o_result = w_a >> 1;
         ALU_SHL_A: o_result = w_a << 1;
         ALU_SHR_B: o_result = w_b >> 1;
         ALU_SHL_B: o_result = w_b << 1;
         default:   o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency result register plus a valid strobe that
// is high only for cycles whose result came from an enabled operation.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int SELECTION_LINE = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     A,
   input  logic [DATA_WIDTH-1:0]     B,
   input  logic [SELECTION_LINE-1:0] ALU_FUN,
   input  logic                      Enable,
   output logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   output logic                      OUT_Valid
);

   logic [2*DATA_WIDTH-1:0] w_result;
   logic [2*DATA_WIDTH-1:0] r_alu_out;
   logic                    r_out_valid;

   alu_core #(
      .DATA_WIDTH     (DATA_WIDTH),
      .SELECTION_LINE (SELECTION_LINE)
   ) u_core (
      .i_a      (A),
      .i_b      (B),
      .i_fun    (ALU_FUN),
      .o_result (w_result)
   );

   // A disabled cycle keeps the last result but drops the strobe.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_alu_out   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= Enable;
         if (Enable) begin
            r_alu_out <= w_result;
         end
      end
   end

   assign ALU_OUT   = r_alu_out;
   assign OUT_Valid = r_out_valid;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan followed by randomized traffic,
// all compared against an integer-arithmetic reference model.
module tb_alu;

   logic        CLK;
   logic        RST;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [3:0]  ALU_FUN;
   logic        Enable;
   logic [15:0] ALU_OUT;
   logic        OUT_Valid;

   int          n_tests;
   int          n_fail;
   logic [15:0] exp_out;
   logic        exp_valid;

   alu #(.DATA_WIDTH(8), .SELECTION_LINE(4)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .A         (A),
      .B         (B),
      .ALU_FUN   (ALU_FUN),
      .Enable    (Enable),
      .ALU_OUT   (ALU_OUT),
      .OUT_Valid (OUT_Valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference: plain integer math on the opcode table, then keep 16 bits.
   function automatic logic [15:0] model(input int fun, input int a, input int b);
      int r;
      case (fun)
         0:  r = a + b;
         1:  r = a - b;
         2:  r = a * b;
         3:  r = (b == 0) ? 0 : a / b;
         4:  r = a & b;
         5:  r = a | b;
         6:  r = 255 - (a & b);
         7:  r = 255 - (a | b);
         8:  r = 0;
         9:  r = (a == b) ? 1 : 0;
         10: r = (a > b) ? 2 : 0;
         11: r = (a < b) ? 3 : 0;
         12: r = a / 2;
         13: r = a * 2;
         14: r = b / 2;
         default: r = b * 2;
      endcase
      return r[15:0];
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b,
                       input logic en);
      @(negedge CLK);
      ALU_FUN = fun;
      A       = a;
      B       = b;
      Enable  = en;
      @(posedge CLK);
      #1;
      if (en) exp_out = model(int'(fun), int'(a), int'(b));
      exp_valid = en;
      $display("[TB] fun=%0d a=%0d b=%0d en=%0b out=%0d vld=%0b",
               fun, a, b, en, ALU_OUT, OUT_Valid);
      check("alu_out", ALU_OUT, exp_out);
      check("out_valid", {15'd0, OUT_Valid}, {15'd0, exp_valid});
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      exp_out   = '0;
      exp_valid = 1'b0;
      RST       = 1'b0;
      A         = 8'd0;
      B         = 8'd0;
      ALU_FUN   = 4'd0;
      Enable    = 1'b1;

      // Reset state while RST is held low, with Enable high.
      @(negedge CLK);
      @(posedge CLK);
      #1;
      check("rst_out", ALU_OUT, 16'd0);
      check("rst_valid", {15'd0, OUT_Valid}, 16'd0);
      @(negedge CLK);
      RST = 1'b1;

      // Arithmetic
      step(4'd0, 8'd10, 8'd5, 1'b1);
      step(4'd1, 8'd10, 8'd5, 1'b1);
      step(4'd2, 8'd10, 8'd5, 1'b1);
      step(4'd3, 8'd10, 8'd5, 1'b1);
      step(4'd0, 8'hFE, 8'd2, 1'b1);
      check("add_carry_const", ALU_OUT, 16'd256);

      // Logic
      step(4'd4, 8'd1, 8'd0, 1'b1);
      step(4'd5, 8'd1, 8'd0, 1'b1);
      step(4'd6, 8'd1, 8'd0, 1'b1);
      check("nand_const", ALU_OUT, 16'd255);
      step(4'd7, 8'd1, 8'd0, 1'b1);
      check("nor_const", ALU_OUT, 16'd254);

      // Compare and NOP
      step(4'd9,  8'd10, 8'd10, 1'b1);
      step(4'd10, 8'd10, 8'd5,  1'b1);
      step(4'd11, 8'd10, 8'd5,  1'b1);
      step(4'd8,  8'd10, 8'd5,  1'b1);

      // Shifts disabled: output holds, then enabled
      for (int i = 12; i < 16; i++) step(4'(i), 8'd8, 8'd16, 1'b0);
      for (int i = 12; i < 16; i++) step(4'(i), 8'd8, 8'd16, 1'b1);
      check("shl_b_const", ALU_OUT, 16'd32);

      // Corners
      step(4'd1, 8'd0,   8'd1,   1'b1);
      check("sub_wrap_const", ALU_OUT, 16'hFFFF);
      step(4'd3, 8'd200, 8'd0,   1'b1);
      step(4'd2, 8'd255, 8'd255, 1'b1);
      check("mul_max_const", ALU_OUT, 16'd65025);
      step(4'd13, 8'hFF, 8'd0,   1'b1);

      // Asynchronous reset between clock edges
      #3;
      RST = 1'b0;
      #1;
      check("async_rst_out", ALU_OUT, 16'd0);
      check("async_rst_valid", {15'd0, OUT_Valid}, 16'd0);
      exp_out   = '0;
      exp_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      step(4'd0, 8'd3, 8'd4, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) rb = 8'd0;
         if ($urandom_range(0, 7) == 0) rb = ra;
         step(4'($urandom_range(0, 15)), ra, rb, ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
